cfglut5_loader: RTL and testbench
=================================

Name: cfglut5_loader

Overview:
- Reconfigurable 5-input LUT bank with a serial configuration loader; the write-side counterpart of the static LUT5 primitive models.
- Accepts a parallel INIT word over a valid/ready handshake and shifts it bit-serially into a CFGLUT5-style chain of NUM_LUTS LUTs, while the LUTs stay readable combinationally.
- Used wherever LUT truth tables must be rewritten at run time under Verilator, such as pattern matchers and runtime-selectable logic functions.

Parameters:
- INIT, 32'h00000000, truth table loaded into every LUT on reset.
- NUM_LUTS, 1, number of LUTs in the serial chain (1..8). W = 32*NUM_LUTS.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- CFG_DATA  input  W  new contents; bits [32k+31:32k] are for LUT k.
- CFG_VALID  input  1  CFG_DATA is valid.
- CFG_READY  output  1  loader is idle and can accept a word.
- CFG_DONE  output  1  one-cycle pulse when a load completes.
- I0, I1, I2, I3, I4  input  1 each  LUT address, shared by all LUTs.
- O6  output  NUM_LUTS  O6[k] = LUT k bit {I4,I3,I2,I1,I0}.
- O5  output  NUM_LUTS  O5[k] = LUT k bit {0,I3,I2,I1,I0}, i.e. the lower 16 entries.
- CDO  output  1  serial cascade out, equal to sr[W-1].

Behaviour:
- Storage:
  - W-bit register sr; LUT k = sr[32k+31:32k].
  - W-bit shadow register; bit counter of clog2(W) bits; FSM with states IDLE and SHIFT.
- Reset (RST=1 at an edge):
  - every 32-bit slice of sr is set to INIT; state goes to IDLE; CFG_DONE=0; counter=0; shadow=0.
  - CFG_READY is 0 while RST is high and 1 from the first cycle after reset.
- IDLE:
  - CFG_READY=1.
  - When CFG_VALID=1 at an edge: shadow<=CFG_DATA, counter<=W-1, state<=SHIFT.
  - sr is not modified in IDLE.
- SHIFT:
  - CFG_READY=0; CFG_VALID is ignored and CFG_DATA must not be sampled.
  - Each edge: sr<={sr[W-2:0], shadow[W-1]}, shadow<={shadow[W-2:0],1'b0}, counter decrements. The shadow MSB goes in first.
  - On the edge where counter==0 (the W-th shift): state<=IDLE, CFG_DONE<=1.
- Latency:
  - Handshake at edge T; shifts at edges T+1..T+W; CFG_DONE=1 and CFG_READY=1 during the cycle after edge T+W.
  - After the load, sr == CFG_DATA exactly.
- CFG_DONE is high for exactly one cycle per completed load and is cleared on the next edge.
- Back-to-back: a new CFG_VALID accepted in the CFG_DONE cycle starts the next load immediately. Sustained throughput is one word per W+1 cycles.
- Reads:
  - O5, O6 and CDO are purely combinational from sr and I0..I4, with zero latency.
  - During SHIFT they reflect the partially shifted contents. This matches hardware and is intentional; consumers must ignore the outputs until CFG_DONE.
- Reset mid-SHIFT: the load is aborted, sr returns to INIT, no CFG_DONE pulse, CFG_READY=1 after reset.
- RST takes priority over every other event at the same edge, including a handshake.
- X/Z on I0..I4 is outside scope; no checking is required.

Test Plan:
- Reset, NUM_LUTS=1, INIT=32'hCAFEBABE; sweep I=0..31 -> O6 matches INIT bit by bit (I=1 gives 1, I=0 gives 0); O5 for I4=1, I3..I0=5 equals INIT[5]=1; CFG_READY=1.
- Load 32'h8000_0001, NUM_LUTS=1, with VALID held for 1 cycle -> READY=0 for 32 cycles; CFG_DONE pulses exactly 1 cycle, 33 cycles after the handshake edge; afterwards O6=1 only for I=0 and I=31.
- NUM_LUTS=2, load {32'hFFFF_0000, 32'h0000_FFFF} -> after 64 shifts O6[0]=1 for I<16 and O6[1]=1 for I>=16; the CDO sequence during the shift equals the old sr MSB-first.
- Back-to-back: second VALID asserted in the CFG_DONE cycle with 32'h1234_5678 -> the second load starts with no idle cycle; second CFG_DONE comes 33 cycles after the first; final sr=32'h1234_5678.
- VALID toggled during SHIFT with different data -> ignored; final contents equal the first accepted word.
- RST asserted at shift 10 of a load of 32'hFFFF_FFFF -> sr=INIT the next cycle, no CFG_DONE, READY=1; a fresh load then completes normally.

Source files
------------

// File: rtl/cfglut5_loader.sv
// Reconfigurable LUT5 bank with a serial configuration loader.
// Words arrive on a valid/ready handshake and are shifted MSB-first into the chain.
module cfglut5_loader #(
  parameter logic [31:0] INIT     = 32'h0000_0000,
  parameter int          NUM_LUTS = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [32*NUM_LUTS-1:0] CFG_DATA,
  input  logic                  CFG_VALID,
  output logic                  CFG_READY,
  output logic                  CFG_DONE,
  input  logic                  I0,
  input  logic                  I1,
  input  logic                  I2,
  input  logic                  I3,
  input  logic                  I4,
  output logic [NUM_LUTS-1:0]   O6,
  output logic [NUM_LUTS-1:0]   O5,
  output logic                  CDO
);

  localparam int W  = 32 * NUM_LUTS;
  localparam int CW = $clog2(W);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t         state;
  logic [W-1:0]   sr;
  logic [W-1:0]   shadow;
  logic [CW-1:0]  cnt;
  logic           done_q;
  logic [4:0]     addr;

  // Loader FSM: latch a word in IDLE, then shift it in one bit per edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sr     <= {NUM_LUTS{INIT}};
      shadow <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
      state  <= IDLE;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (CFG_VALID) begin
            shadow <= CFG_DATA;
            cnt    <= CW'(W - 1);
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          sr     <= {sr[W-2:0], shadow[W-1]};
          shadow <= {shadow[W-2:0], 1'b0};
          cnt    <= cnt - CW'(1);
          if (cnt == '0) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign addr      = {I4, I3, I2, I1, I0};
  assign CFG_READY = (state == IDLE) & ~RST;
  assign CFG_DONE  = done_q;
  assign CDO       = sr[W-1];

  for (genvar k = 0; k < NUM_LUTS; k++) begin : g_lut
    logic [31:0] lut;
    assign lut   = sr[32*k +: 32];
    assign O6[k] = lut[addr];
    assign O5[k] = lut[{1'b0, addr[3:0]}];
  end

endmodule

// File: tb/tb_cfglut5_loader.sv
// Self-checking bench for cfglut5_loader.
// Two instances: a single LUT and a two-LUT chain.
`timescale 1ns/1ps
module tb_cfglut5_loader;

  localparam logic [31:0] INIT1 = 32'hCAFE_BABE;
  localparam logic [31:0] INIT2 = 32'h5A3C_96E1;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [4:0]  addr;

  logic        rst1, valid1;
  logic [31:0] data1;
  logic        ready1, done1, cdo1;
  logic [0:0]  o6_1, o5_1;

  logic        rst2, valid2;
  logic [63:0] data2;
  logic        ready2, done2, cdo2;
  logic [1:0]  o6_2, o5_2;

  logic [31:0] m1;
  logic [63:0] m2;
  int passed = 0;
  int total  = 0;

  cfglut5_loader #(.INIT(INIT1), .NUM_LUTS(1)) dut1 (
    .CLK(CLK), .RST(rst1), .CFG_DATA(data1), .CFG_VALID(valid1),
    .CFG_READY(ready1), .CFG_DONE(done1),
    .I0(addr[0]), .I1(addr[1]), .I2(addr[2]), .I3(addr[3]), .I4(addr[4]),
    .O6(o6_1), .O5(o5_1), .CDO(cdo1)
  );

  cfglut5_loader #(.INIT(INIT2), .NUM_LUTS(2)) dut2 (
    .CLK(CLK), .RST(rst2), .CFG_DATA(data2), .CFG_VALID(valid2),
    .CFG_READY(ready2), .CFG_DONE(done2),
    .I0(addr[0]), .I1(addr[1]), .I2(addr[2]), .I3(addr[3]), .I4(addr[4]),
    .O6(o6_2), .O5(o5_2), .CDO(cdo2)
  );

  task automatic sweep1(input string tag);
    logic [3:0] lo;
    for (int a = 0; a < 32; a++) begin
      addr = 5'(a);
      lo = addr[3:0];
      #1;
      total++;
      if (o6_1[0] !== m1[a]) $display("FAIL %s o6 I=%0d got %b want %b", tag, a, o6_1[0], m1[a]);
      else passed++;
      total++;
      if (o5_1[0] !== m1[lo]) $display("FAIL %s o5 I=%0d got %b want %b", tag, a, o5_1[0], m1[lo]);
      else passed++;
    end
  endtask

  task automatic sweep2(input string tag);
    logic [3:0] lo;
    for (int a = 0; a < 32; a++) begin
      addr = 5'(a);
      lo = addr[3:0];
      #1;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (o6_2[k] !== m2[32*k+a])
          $display("FAIL %s o6[%0d] I=%0d got %b want %b", tag, k, a, o6_2[k], m2[32*k+a]);
        else passed++;
        total++;
        if (o5_2[k] !== m2[32*k+lo])
          $display("FAIL %s o5[%0d] I=%0d got %b want %b", tag, k, a, o5_2[k], m2[32*k+lo]);
        else passed++;
      end
    end
  endtask

  // Caller has just placed valid1/data1 at a negedge; returns at the done negedge.
  task automatic run_load1(input logic [31:0] d, input bit toggle, input string tag);
    logic [63:0] vec;
    vec = {m1, d};
    total++;
    if (ready1 !== 1'b1) $display("FAIL %s ready at handshake got %b want 1", tag, ready1);
    else passed++;
    for (int k = 1; k <= 33; k++) begin
      @(negedge CLK);
      total++;
      if (ready1 !== (k == 33)) $display("FAIL %s ready k=%0d got %b want %b", tag, k, ready1, k == 33);
      else passed++;
      total++;
      if (done1 !== (k == 33)) $display("FAIL %s done k=%0d got %b want %b", tag, k, done1, k == 33);
      else passed++;
      total++;
      if (cdo1 !== vec[64-k]) $display("FAIL %s cdo k=%0d got %b want %b", tag, k, cdo1, vec[64-k]);
      else passed++;
      if (toggle && k < 32) begin
        valid1 = 1'($urandom_range(0, 1));
        data1  = $urandom;
      end else begin
        valid1 = 1'b0;
      end
    end
    m1 = d;
  endtask

  task automatic run_load2(input logic [63:0] d, input string tag);
    logic [127:0] vec;
    vec = {m2, d};
    total++;
    if (ready2 !== 1'b1) $display("FAIL %s ready at handshake got %b want 1", tag, ready2);
    else passed++;
    for (int k = 1; k <= 65; k++) begin
      @(negedge CLK);
      total++;
      if (ready2 !== (k == 65)) $display("FAIL %s ready k=%0d got %b want %b", tag, k, ready2, k == 65);
      else passed++;
      total++;
      if (done2 !== (k == 65)) $display("FAIL %s done k=%0d got %b want %b", tag, k, done2, k == 65);
      else passed++;
      total++;
      if (cdo2 !== vec[128-k]) $display("FAIL %s cdo k=%0d got %b want %b", tag, k, cdo2, vec[128-k]);
      else passed++;
      valid2 = 1'b0;
    end
    m2 = d;
  endtask

  task automatic check_done_clear1(input string tag);
    @(negedge CLK);
    total++;
    if (done1 !== 1'b0) $display("FAIL %s done not cleared got %b want 0", tag, done1);
    else passed++;
  endtask

  task automatic test_reset();
    rst1 = 1'b1; rst2 = 1'b1;
    valid1 = 1'b0; valid2 = 1'b0;
    data1 = '0; data2 = '0; addr = '0;
    repeat (3) @(negedge CLK);
    total++;
    if (ready1 !== 1'b0) $display("FAIL reset ready1 in reset got %b want 0", ready1);
    else passed++;
    total++;
    if (ready2 !== 1'b0) $display("FAIL reset ready2 in reset got %b want 0", ready2);
    else passed++;
    rst1 = 1'b0; rst2 = 1'b0;
    @(negedge CLK);
    total++;
    if (ready1 !== 1'b1 || done1 !== 1'b0)
      $display("FAIL reset ready1/done1 got %b/%b want 1/0", ready1, done1);
    else passed++;
    total++;
    if (ready2 !== 1'b1 || done2 !== 1'b0)
      $display("FAIL reset ready2/done2 got %b/%b want 1/0", ready2, done2);
    else passed++;
    m1 = INIT1;
    m2 = {INIT2, INIT2};
    sweep1("reset1");
    sweep2("reset2");
    addr = 5'd21;
    #1;
    total++;
    if (o5_1[0] !== 1'b1) $display("FAIL reset o5 I=21 got %b want 1", o5_1[0]);
    else passed++;
  endtask

  task automatic test_single_load();
    @(negedge CLK);
    data1 = 32'h8000_0001; valid1 = 1'b1;
    run_load1(32'h8000_0001, 1'b0, "load1");
    check_done_clear1("load1");
    sweep1("load1");
    for (int a = 0; a < 32; a++) begin
      addr = 5'(a);
      #1;
      total++;
      if (o6_1[0] !== (a == 0 || a == 31)) $display("FAIL load1 corner I=%0d got %b", a, o6_1[0]);
      else passed++;
    end
  endtask

  task automatic test_dual();
    logic [63:0] d;
    @(negedge CLK);
    d = {32'hFFFF_0000, 32'h0000_FFFF};
    data2 = d; valid2 = 1'b1;
    run_load2(d, "dual");
    sweep2("dual");
    for (int r = 0; r < 2; r++) begin
      @(negedge CLK);
      d = {$urandom, $urandom};
      data2 = d; valid2 = 1'b1;
      run_load2(d, "dual_rand");
      sweep2("dual_rand");
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    @(negedge CLK);
    d = $urandom;
    data1 = d; valid1 = 1'b1;
    run_load1(d, 1'b0, "b2b_first");
    data1 = 32'h1234_5678; valid1 = 1'b1;
    run_load1(32'h1234_5678, 1'b0, "b2b_second");
    check_done_clear1("b2b");
    sweep1("b2b");
  endtask

  task automatic test_toggle();
    logic [31:0] d;
    for (int r = 0; r < 4; r++) begin
      @(negedge CLK);
      d = $urandom;
      data1 = d; valid1 = 1'b1;
      run_load1(d, 1'b1, "toggle");
      check_done_clear1("toggle");
      sweep1("toggle");
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [31:0] d;
    @(negedge CLK);
    data1 = 32'hFFFF_FFFF; valid1 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      valid1 = 1'b0;
      total++;
      if (done1 !== 1'b0 || ready1 !== 1'b0)
        $display("FAIL abort pre k=%0d done/ready got %b/%b want 0/0", k, done1, ready1);
      else passed++;
    end
    rst1 = 1'b1;
    @(negedge CLK);
    total++;
    if (ready1 !== 1'b0 || done1 !== 1'b0)
      $display("FAIL abort in reset ready/done got %b/%b want 0/0", ready1, done1);
    else passed++;
    m1 = INIT1;
    sweep1("abort");
    @(negedge CLK);
    rst1 = 1'b0;
    @(negedge CLK);
    total++;
    if (ready1 !== 1'b1 || done1 !== 1'b0)
      $display("FAIL abort after reset ready/done got %b/%b want 1/0", ready1, done1);
    else passed++;
    d = $urandom;
    data1 = d; valid1 = 1'b1;
    run_load1(d, 1'b0, "abort_reload");
    check_done_clear1("abort_reload");
    sweep1("abort_reload");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_load();
    test_dual();
    test_back_to_back();
    test_toggle();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
